// File: rtl/cva6_l2_tlb_2m.sv
// cva6_l2_tlb_2m: set-associative L2 TLB for Sv39 2 MiB megapages.
// Optional VMID tagging: define CVA6_L2TLB_VMID_EN.
`timescale 1ns/1ps
module cva6_l2_tlb_2m #(
  parameter int NR_ENTRIES = 32,
  parameter int ASSOC      = 4,
  parameter int ASID_WIDTH = 16,
  parameter int VMID_WIDTH = 14,
  parameter int PPN_WIDTH  = 44
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  flush_asid_valid_i,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  input  logic                  lookup_valid_i,
  output logic                  lookup_ready_o,
  input  logic [26:0]           lookup_vpn_i,
  input  logic [ASID_WIDTH-1:0] lookup_asid_i,
  input  logic [VMID_WIDTH-1:0] lookup_vmid_i,
  output logic                  hit_valid_o,
  output logic                  hit_o,
  output logic [PPN_WIDTH-10:0] hit_ppn_o,
  output logic [7:0]            hit_flags_o,
  input  logic                  refill_valid_i,
  input  logic [26:0]           refill_vpn_i,
  input  logic [ASID_WIDTH-1:0] refill_asid_i,
  input  logic [VMID_WIDTH-1:0] refill_vmid_i,
  input  logic [PPN_WIDTH-10:0] refill_ppn_i,
  input  logic [7:0]            refill_flags_i
);

  localparam int SETS = NR_ENTRIES / ASSOC;
  localparam int IW   = $clog2(SETS);
  localparam int WW   = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam int TW   = 27 - 9 - IW;
  localparam int PW   = PPN_WIDTH - 9;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e state_q, state_d;
  logic [IW-1:0] fl_cnt_q, fl_cnt_d;
  logic fl_asid_vld_q;
  logic [ASID_WIDTH-1:0] fl_asid_q;

  logic [ASSOC-1:0] vld_q [SETS];
  logic [WW-1:0] rr_q [SETS];
  logic [TW-1:0] tag_q [SETS][ASSOC];
  logic [ASID_WIDTH-1:0] asid_q [SETS][ASSOC];
  logic [PW-1:0] ppn_q [SETS][ASSOC];
  logic [7:0] flg_q [SETS][ASSOC];

  logic req_vld_q;
  logic [IW-1:0] req_idx_q;
  logic [TW-1:0] req_tag_q;
  logic [ASID_WIDTH-1:0] req_asid_q;

  logic lk_acc;
  logic lk_hit;
  logic [PW-1:0] lk_ppn;
  logic [7:0] lk_flg;

  logic [IW-1:0] rf_idx;
  logic [TW-1:0] rf_tag;
  logic rf_we, rf_hit, rf_free, rf_adv;
  logic [WW-1:0] rf_hway, rf_fway, rf_way, rr_nxt;

  logic [ASSOC-1:0] lk_vm, rf_vm, fl_vm;

`ifdef CVA6_L2TLB_VMID_EN
  logic [VMID_WIDTH-1:0] vmid_q [SETS][ASSOC];
  logic [VMID_WIDTH-1:0] req_vmid_q;
  logic [VMID_WIDTH-1:0] fl_vmid_q;
  logic unused_bits;
  assign unused_bits = ^{lookup_vpn_i[8:0], refill_vpn_i[8:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{lookup_vpn_i[8:0], refill_vpn_i[8:0],
                         lookup_vmid_i, refill_vmid_i};
`endif

  assign lookup_ready_o = (state_q == S_IDLE) & ~flush_i & ~refill_valid_i;
  assign lk_acc = lookup_valid_i & lookup_ready_o;

  assign rf_idx = refill_vpn_i[9 +: IW];
  assign rf_tag = refill_vpn_i[26 -: TW];
  assign rf_we  = refill_valid_i & (state_q == S_IDLE) & ~flush_i;
  assign rf_adv = rf_we & ~rf_hit & ~rf_free;
  assign rr_nxt = (rr_q[rf_idx] == WW'(ASSOC-1)) ? '0 : rr_q[rf_idx] + 1'b1;

  // Per-way VMID agreement; all-ones when VMID tagging is off
  always_comb begin
    lk_vm = '1;
    rf_vm = '1;
    fl_vm = '1;
`ifdef CVA6_L2TLB_VMID_EN
    for (int w = 0; w < ASSOC; w++) begin
      lk_vm[w] = vmid_q[req_idx_q][w] == req_vmid_q;
      rf_vm[w] = vmid_q[rf_idx][w] == refill_vmid_i;
      fl_vm[w] = vmid_q[fl_cnt_q][w] == fl_vmid_q;
    end
`endif
  end

  // Tag compare for the registered lookup; lowest matching way wins
  always_comb begin
    lk_hit = 1'b0;
    lk_ppn = '0;
    lk_flg = '0;
    for (int w = ASSOC-1; w >= 0; w--) begin
      if (vld_q[req_idx_q][w] &&
          tag_q[req_idx_q][w] == req_tag_q &&
          (flg_q[req_idx_q][w][5] ||
           asid_q[req_idx_q][w] == req_asid_q) &&
          lk_vm[w]) begin
        lk_hit = 1'b1;
        lk_ppn = ppn_q[req_idx_q][w];
        lk_flg = flg_q[req_idx_q][w];
      end
    end
  end

  // Refill way: existing match, else lowest free way, else round-robin
  always_comb begin
    rf_hit  = 1'b0;
    rf_hway = '0;
    rf_free = 1'b0;
    rf_fway = '0;
    for (int w = ASSOC-1; w >= 0; w--) begin
      if (vld_q[rf_idx][w] &&
          tag_q[rf_idx][w] == rf_tag &&
          (flg_q[rf_idx][w][5] ||
           asid_q[rf_idx][w] == refill_asid_i) &&
          rf_vm[w]) begin
        rf_hit  = 1'b1;
        rf_hway = WW'(w);
      end
      if (!vld_q[rf_idx][w]) begin
        rf_free = 1'b1;
        rf_fway = WW'(w);
      end
    end
    rf_way = rf_hit ? rf_hway : (rf_free ? rf_fway : rr_q[rf_idx]);
  end

  // Flush sequencer next state
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d  = S_FLUSH;
          fl_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        fl_cnt_d = fl_cnt_q + 1'b1;
        if (fl_cnt_q == IW'(SETS-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flush state register and latched flush qualifiers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      fl_cnt_q      <= '0;
      fl_asid_vld_q <= 1'b0;
      fl_asid_q     <= '0;
`ifdef CVA6_L2TLB_VMID_EN
      fl_vmid_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fl_cnt_q <= fl_cnt_d;
      if (state_q == S_IDLE && flush_i) begin
        fl_asid_vld_q <= flush_asid_valid_i;
        fl_asid_q     <= flush_asid_i;
`ifdef CVA6_L2TLB_VMID_EN
        fl_vmid_q     <= lookup_vmid_i;
`endif
      end
    end
  end

  // Valid bits and replacement pointers: flush walk or refill
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        rr_q[s]  <= '0;
      end
    end else if (state_q == S_FLUSH) begin
      if (!fl_asid_vld_q) begin
        vld_q[fl_cnt_q] <= '0;
        rr_q[fl_cnt_q]  <= '0;
      end else begin
        for (int w = 0; w < ASSOC; w++) begin
          if (vld_q[fl_cnt_q][w] && !flg_q[fl_cnt_q][w][5] &&
              asid_q[fl_cnt_q][w] == fl_asid_q && fl_vm[w])
            vld_q[fl_cnt_q][w] <= 1'b0;
        end
      end
    end else if (rf_we) begin
      vld_q[rf_idx][rf_way] <= 1'b1;
      if (rf_adv) rr_q[rf_idx] <= rr_nxt;
    end
  end

  // Entry payload storage; meaningless until the valid bit is set
  always_ff @(posedge clk_i) begin
    if (rf_we) begin
      tag_q[rf_idx][rf_way]  <= rf_tag;
      asid_q[rf_idx][rf_way] <= refill_asid_i;
      ppn_q[rf_idx][rf_way]  <= refill_ppn_i;
      flg_q[rf_idx][rf_way]  <= refill_flags_i;
`ifdef CVA6_L2TLB_VMID_EN
      vmid_q[rf_idx][rf_way] <= refill_vmid_i;
`endif
    end
  end

  // Capture accepted lookup request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_vld_q  <= 1'b0;
      req_idx_q  <= '0;
      req_tag_q  <= '0;
      req_asid_q <= '0;
`ifdef CVA6_L2TLB_VMID_EN
      req_vmid_q <= '0;
`endif
    end else begin
      req_vld_q <= lk_acc;
      if (lk_acc) begin
        req_idx_q  <= lookup_vpn_i[9 +: IW];
        req_tag_q  <= lookup_vpn_i[26 -: TW];
        req_asid_q <= lookup_asid_i;
`ifdef CVA6_L2TLB_VMID_EN
        req_vmid_q <= lookup_vmid_i;
`endif
      end
    end
  end

  // Register the lookup response; payload zeroed on miss
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_valid_o <= 1'b0;
      hit_o       <= 1'b0;
      hit_ppn_o   <= '0;
      hit_flags_o <= '0;
    end else begin
      hit_valid_o <= req_vld_q;
      hit_o       <= req_vld_q & lk_hit;
      hit_ppn_o   <= (req_vld_q & lk_hit) ? lk_ppn : '0;
      hit_flags_o <= (req_vld_q & lk_hit) ? lk_flg : '0;
    end
  end

endmodule
